// File: rtl/rom_boot_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_boot_loader_pkg
//  Description : Shared types and constants for the ROM boot loader.
//                Holds the loader state encoding, the byte/word geometry and
//                the byte-lane counter width used by the packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_boot_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;
    localparam int LANE_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rom_boot_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : rom_boot_loader_if
//  Description : ROM read port and memory write port of the boot loader.
//                master : the loader (drives rom_address and the mem_* write
//                         request, receives rom_byte/rom_done/mem_wready)
//                slave  : the ROM + memory side
//  Ports       : rom_address[31:0], rom_byte[7:0], rom_done,
//                mem_addr[31:0], mem_wdata[31:0], mem_wvalid, mem_wready
//  Revision    : 1.0 - initial release
// ============================================================================
interface rom_boot_loader_if;
    import rom_boot_loader_pkg::*;

    logic [31:0]       rom_address;
    logic [BYTE_W-1:0] rom_byte;
    logic              rom_done;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_wvalid;
    logic              mem_wready;

    modport master (
        output rom_address,
        input  rom_byte,
        input  rom_done,
        output mem_addr,
        output mem_wdata,
        output mem_wvalid,
        input  mem_wready
    );

    modport slave (
        input  rom_address,
        output rom_byte,
        output rom_done,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wvalid,
        output mem_wready
    );

endinterface
`default_nettype wire

// File: rtl/rom_boot_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : rom_boot_loader_byte_packer
//  Description : Little-endian byte-to-word packer. Each load places byte_in
//                into the current lane and advances the lane; clear zeroes the
//                word and returns to lane 0, so unfilled upper lanes of a
//                partial word read as zero.
//  Ports       : clk, reset_n (sync, active-low), clear, load,
//                byte_in[7:0], lane[1:0], word[31:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_boot_loader_byte_packer
    import rom_boot_loader_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire logic                  clear,
    input  wire logic                  load,
    input  wire logic [BYTE_W-1:0]     byte_in,
    output logic [LANE_W-1:0]          lane,
    output logic [WORD_BYTES*BYTE_W-1:0] word
);

    logic [LANE_W-1:0]            r_lane;
    logic [WORD_BYTES*BYTE_W-1:0] r_word;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (load) begin
            r_word[r_lane*BYTE_W +: BYTE_W] <= byte_in;
            r_lane                          <= r_lane + 1'b1;
        end
    end

    assign lane = r_lane;
    assign word = r_word;

endmodule
`default_nettype wire

// File: rtl/rom_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : rom_boot_loader
//  Description : Copies the program ROM into main memory before the CPU runs.
//                Reads one ROM byte per cycle from address 0 upward, packs
//                four bytes little-endian into a word and writes it over a
//                valid/ready port, holding the CPU in reset until the copy
//                finishes cleanly.
//  Ports       : clk, reset_n (sync, active-low), start (level),
//                bus (rom_boot_loader_if.master: ROM read + memory write),
//                busy, loaded, overflow, word_count[31:0], cpu_reset_n
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_boot_loader
    import rom_boot_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_BYTES = 65536
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    input  wire logic         start,
    rom_boot_loader_if.master bus,
    output logic              busy,
    output logic              loaded,
    output logic              overflow,
    output logic [31:0]       word_count,
    output logic              cpu_reset_n
);

    localparam logic [31:0]       c_MAX_ADDR  = 32'(MAX_BYTES - 1);
    localparam logic [LANE_W-1:0] c_LAST_LANE = LANE_W'(WORD_BYTES - 1);
    localparam logic [31:0]       c_ADDR_STEP = 32'(WORD_BYTES);

    state_t      r_state;
    logic [31:0] r_rom_address;
    logic [31:0] r_mem_addr;
    logic [31:0] r_word_count;
    logic        r_wvalid;
    logic        r_busy;
    logic        r_loaded;
    logic        r_overflow;
    logic        r_cpu_reset_n;
    logic        r_last_word;

    logic                          w_start_ok;
    logic                          w_at_max;
    logic                          w_end;
    logic                          w_hs;
    logic                          w_pack_clear;
    logic                          w_pack_load;
    logic [LANE_W-1:0]             w_lane;
    logic [WORD_BYTES*BYTE_W-1:0]  w_word;

    assign w_start_ok = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
    assign w_at_max   = (r_rom_address == c_MAX_ADDR);
    // Either the ROM says this is its last byte or the byte ceiling is hit.
    assign w_end      = bus.rom_done || w_at_max;
    assign w_hs       = r_wvalid && bus.mem_wready;

    // The packer is cleared at the start of a load and after every accepted
    // word that is not the last, so the next word starts at lane 0 from zero.
    assign w_pack_clear = w_start_ok ||
                          ((r_state == ST_WRITE) && w_hs && !r_last_word);
    assign w_pack_load  = (r_state == ST_FETCH);

    rom_boot_loader_byte_packer u_packer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_pack_clear),
        .load    (w_pack_load),
        .byte_in (bus.rom_byte),
        .lane    (w_lane),
        .word    (w_word)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_rom_address <= '0;
            r_mem_addr    <= BASE_ADDR;
            r_word_count  <= '0;
            r_wvalid      <= 1'b0;
            r_busy        <= 1'b0;
            r_loaded      <= 1'b0;
            r_overflow    <= 1'b0;
            r_cpu_reset_n <= 1'b0;
            r_last_word   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state       <= ST_FETCH;
                        r_rom_address <= '0;
                        r_mem_addr    <= BASE_ADDR;
                        r_word_count  <= '0;
                        r_overflow    <= 1'b0;
                        r_loaded      <= 1'b0;
                        r_cpu_reset_n <= 1'b0;
                        r_busy        <= 1'b1;
                        r_last_word   <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    // Hold the address on the final byte so it never passes
                    // the ceiling; otherwise step to the next byte.
                    if (!w_end) begin
                        r_rom_address <= r_rom_address + 32'd1;
                    end
                    // A done on lane 3 closes the current word only, so no
                    // empty trailing word is produced.
                    if (w_end || (w_lane == c_LAST_LANE)) begin
                        r_state     <= ST_WRITE;
                        r_wvalid    <= 1'b1;
                        r_last_word <= w_end;
                        if (w_at_max && !bus.rom_done) begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_hs) begin
                        r_wvalid     <= 1'b0;
                        r_word_count <= r_word_count + 32'd1;
                        r_mem_addr   <= r_mem_addr + c_ADDR_STEP;
                        if (r_last_word) begin
                            r_state       <= ST_DONE;
                            r_busy        <= 1'b0;
                            r_loaded      <= 1'b1;
                            r_cpu_reset_n <= !r_overflow;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rom_address = r_rom_address;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = w_word;
    assign bus.mem_wvalid  = r_wvalid;
    assign busy            = r_busy;
    assign loaded          = r_loaded;
    assign overflow        = r_overflow;
    assign word_count      = r_word_count;
    assign cpu_reset_n     = r_cpu_reset_n;

endmodule
`default_nettype wire

// File: tb/tb_rom_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_boot_loader
//  Description : Directed self-checking bench for rom_boot_loader. Instance A
//                copies a 54-byte ROM (base 0x1000); instance B has no ROM
//                done and an 8-byte ceiling.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_boot_loader;

    localparam logic [31:0] c_BASE_A = 32'h0000_1000;
    localparam int          c_ROM_LEN = 54;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic wready_a = 1'b1;
    logic stall_a = 1'b0;
    int   wcnt_a = 0;
    logic [31:0] done_addr_a = 32'd53;
    logic [7:0]  rom_mem [0:c_ROM_LEN-1];

    logic busy_a, loaded_a, overflow_a, cpu_rst_a;
    logic busy_b, loaded_b, overflow_b, cpu_rst_b;
    logic [31:0] wc_a, wc_b;

    int checks = 0;
    int errors = 0;
    int stable_err = 0;
    int n;
    int qsize;

    logic [31:0] qa_addr[$];
    logic [31:0] qa_data[$];
    logic [31:0] qb_addr[$];
    logic [31:0] qb_data[$];

    always #5 clk = ~clk;

    rom_boot_loader_if bus_a ();
    rom_boot_loader_if bus_b ();

    assign bus_a.rom_byte   = (bus_a.rom_address < 32'(c_ROM_LEN)) ?
                              rom_mem[bus_a.rom_address[5:0]] : 8'h00;
    assign bus_a.rom_done   = (bus_a.rom_address == done_addr_a);
    assign bus_a.mem_wready = wready_a;

    assign bus_b.rom_byte   = bus_b.rom_address[7:0] ^ 8'hA5;
    assign bus_b.rom_done   = 1'b0;
    assign bus_b.mem_wready = 1'b1;

    rom_boot_loader #(.BASE_ADDR(c_BASE_A), .MAX_BYTES(65536)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .bus(bus_a),
        .busy(busy_a), .loaded(loaded_a), .overflow(overflow_a),
        .word_count(wc_a), .cpu_reset_n(cpu_rst_a)
    );

    rom_boot_loader #(.BASE_ADDR(32'h0), .MAX_BYTES(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .bus(bus_b),
        .busy(busy_b), .loaded(loaded_b), .overflow(overflow_b),
        .word_count(wc_b), .cpu_reset_n(cpu_rst_b)
    );

    // Memory-side ready: either always ready, or low for 3 cycles of each write.
    always @(negedge clk) begin
        if (!stall_a) begin
            wready_a = 1'b1;
            wcnt_a   = 0;
        end else if (bus_a.mem_wvalid) begin
            if (wcnt_a == 3) begin
                wready_a = 1'b1;
                wcnt_a   = 0;
            end else begin
                wready_a = 1'b0;
                wcnt_a   = wcnt_a + 1;
            end
        end else begin
            wready_a = 1'b0;
            wcnt_a   = 0;
        end
    end

    // Capture accepted writes and watch that a stalled request stays stable.
    logic        pv = 1'b0, pr = 1'b0;
    logic [31:0] pa = '0, pd = '0;
    always @(posedge clk) begin
        if (reset_n) begin
            if (bus_a.mem_wvalid && bus_a.mem_wready) begin
                qa_addr.push_back(bus_a.mem_addr);
                qa_data.push_back(bus_a.mem_wdata);
            end
            if (bus_b.mem_wvalid && bus_b.mem_wready) begin
                qb_addr.push_back(bus_b.mem_addr);
                qb_data.push_back(bus_b.mem_wdata);
            end
            if (pv && !pr) begin
                if (!bus_a.mem_wvalid || bus_a.mem_addr != pa || bus_a.mem_wdata != pd)
                    stable_err = stable_err + 1;
            end
        end
        pv = bus_a.mem_wvalid;
        pr = bus_a.mem_wready;
        pa = bus_a.mem_addr;
        pd = bus_a.mem_wdata;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rom_at(input int i);
        return (i < c_ROM_LEN) ? rom_mem[i] : 8'h00;
    endfunction

    function automatic logic [31:0] exp_word(input int w);
        return {rom_at(4*w+3), rom_at(4*w+2), rom_at(4*w+1), rom_at(4*w)};
    endfunction

    task automatic wait_loaded_a(input int limit);
        while (!loaded_a && n < limit) begin
            tick;
            n++;
        end
    endtask

    task automatic check_full_load_a(input string tag);
        check({tag, "_nwrites"}, 32'(qa_addr.size()), 32'd14);
        if (qa_addr.size() == 14) begin
            for (int w = 0; w < 14; w++) begin
                check($sformatf("%s_addr%0d", tag, w), qa_addr[w], c_BASE_A + 32'(4*w));
                check($sformatf("%s_data%0d", tag, w), qa_data[w], exp_word(w));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < c_ROM_LEN; i++) rom_mem[i] = 8'(i*13 + 5);
        rom_mem[0]  = 8'h22; rom_mem[1]  = 8'h01; rom_mem[2]  = 8'h00; rom_mem[3]  = 8'h00;
        rom_mem[8]  = 8'h0E; rom_mem[9]  = 8'h01; rom_mem[10] = 8'h00; rom_mem[11] = 8'h00;
        rom_mem[52] = 8'h00; rom_mem[53] = 8'h00;

        // Reset state
        tick; tick;
        check("rst_rom_address", bus_a.rom_address, 32'd0);
        check("rst_mem_addr", bus_a.mem_addr, c_BASE_A);
        check("rst_mem_wdata", bus_a.mem_wdata, 32'd0);
        check("rst_mem_wvalid", 32'(bus_a.mem_wvalid), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_loaded", 32'(loaded_a), 32'd0);
        check("rst_overflow", 32'(overflow_a), 32'd0);
        check("rst_word_count", wc_a, 32'd0);
        check("rst_cpu_reset_n", 32'(cpu_rst_a), 32'd0);
        reset_n = 1'b1;
        tick;

        // 1. Full 54-byte load, ready tied high
        start_a = 1'b1; tick; start_a = 1'b0; n = 0;
        check("t1_busy", 32'(busy_a), 32'd1);
        wait_loaded_a(1000);
        check("t1_cycles", 32'(n), 32'd68);
        check_full_load_a("t1");
        if (qa_data.size() == 14) begin
            check("t1_word0", qa_data[0], 32'h0000_0122);
            check("t1_word1", qa_data[1], 32'h6053_4639);
            check("t1_word2", qa_data[2], 32'h0000_010E);
            check("t1_word12", qa_data[12], 32'h9C8F_8275);
            check("t1_word13", qa_data[13], 32'h0000_0000);
            check("t1_addr13", qa_addr[13], c_BASE_A + 32'd52);
        end
        check("t1_word_count", wc_a, 32'd14);
        check("t1_cpu_reset_n", 32'(cpu_rst_a), 32'd1);
        check("t1_busy_done", 32'(busy_a), 32'd0);
        check("t1_overflow", 32'(overflow_a), 32'd0);

        // 2. Same ROM with 3 stall cycles per write
        qa_addr.delete(); qa_data.delete(); stable_err = 0; stall_a = 1'b1;
        start_a = 1'b1; tick; start_a = 1'b0; n = 0;
        wait_loaded_a(2000);
        check("t2_cycles", 32'(n), 32'd110);
        check_full_load_a("t2");
        check("t2_stable", 32'(stable_err), 32'd0);
        check("t2_word_count", wc_a, 32'd14);
        stall_a = 1'b0;
        tick;

        // 3. rom_done on lane 3 of the first word
        qa_addr.delete(); qa_data.delete(); done_addr_a = 32'd3;
        start_a = 1'b1; tick; start_a = 1'b0; n = 0;
        wait_loaded_a(200);
        check("t3_cycles", 32'(n), 32'd5);
        repeat (4) tick;
        check("t3_nwrites", 32'(qa_addr.size()), 32'd1);
        if (qa_addr.size() >= 1) begin
            check("t3_data", qa_data[0], 32'h0000_0122);
            check("t3_addr", qa_addr[0], c_BASE_A);
        end
        check("t3_word_count", wc_a, 32'd1);
        check("t3_cpu_reset_n", 32'(cpu_rst_a), 32'd1);
        done_addr_a = 32'd53;

        // 4. No rom_done, 8-byte ceiling
        start_b = 1'b1; tick; start_b = 1'b0; n = 0;
        while (!loaded_b && n < 200) begin tick; n++; end
        check("t4_cycles", 32'(n), 32'd10);
        check("t4_nwrites", 32'(qb_addr.size()), 32'd2);
        if (qb_addr.size() == 2) begin
            check("t4_data0", qb_data[0], 32'hA6A7_A4A5);
            check("t4_data1", qb_data[1], 32'hA2A3_A0A1);
            check("t4_addr1", qb_addr[1], 32'd4);
        end
        check("t4_overflow", 32'(overflow_b), 32'd1);
        check("t4_loaded", 32'(loaded_b), 32'd1);
        check("t4_cpu_reset_n", 32'(cpu_rst_b), 32'd0);
        check("t4_word_count", wc_b, 32'd2);
        check("t4_rom_address", bus_b.rom_address, 32'd7);

        // 5. Reset during the write of word 5
        qa_addr.delete(); qa_data.delete();
        start_a = 1'b1; tick; start_a = 1'b0; n = 0;
        while (!(wc_a == 32'd5 && bus_a.mem_wvalid) && n < 200) begin tick; n++; end
        check("t5_reached_word5", 32'(n), 32'd29);
        reset_n = 1'b0; tick;
        check("t5_wvalid", 32'(bus_a.mem_wvalid), 32'd0);
        check("t5_word_count", wc_a, 32'd0);
        check("t5_busy", 32'(busy_a), 32'd0);
        qsize = qa_addr.size();
        reset_n = 1'b1;
        repeat (6) tick;
        check("t5_no_writes", 32'(qsize), 32'd5);
        check("t5_no_more", 32'(qa_addr.size()), 32'd5);
        check("t5_idle_busy", 32'(busy_a), 32'd0);
        qa_addr.delete(); qa_data.delete();
        start_a = 1'b1; tick; start_a = 1'b0; n = 0;
        wait_loaded_a(1000);
        check("t5_cycles", 32'(n), 32'd68);
        check_full_load_a("t5");

        // 6. start held through a load, then pulsed in DONE
        qa_addr.delete(); qa_data.delete();
        start_a = 1'b1; tick; n = 0;
        repeat (30) begin tick; n++; end
        check("t6_busy_held", 32'(busy_a), 32'd1);
        check("t6_wc_held", wc_a, 32'd6);
        check("t6_addr_held", bus_a.rom_address, 32'd24);
        start_a = 1'b0;
        wait_loaded_a(1000);
        check("t6_cycles", 32'(n), 32'd68);
        check_full_load_a("t6a");
        qa_addr.delete(); qa_data.delete();
        tick;
        start_a = 1'b1; tick; start_a = 1'b0; n = 0;
        check("t6_restart_busy", 32'(busy_a), 32'd1);
        check("t6_restart_loaded", 32'(loaded_a), 32'd0);
        check("t6_restart_wc", wc_a, 32'd0);
        check("t6_restart_cpu", 32'(cpu_rst_a), 32'd0);
        wait_loaded_a(1000);
        check("t6_cycles2", 32'(n), 32'd68);
        check_full_load_a("t6b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
